half_img_merge: RTL and testbench
=================================

// Module: half_img_merge
// PURPOSE
//  Inverse of the half_img splitter. Takes a half-width stream in which each active cycle
//  carries a left and a right pixel, and rebuilds one full-width side-by-side line: HALF_IMG_W
//  left pixels followed by HALF_IMG_W right pixels. Sits at the end of the stereo pipeline
//  (before grayscale_out / hdmi_out) so left/right results can be shown together on one frame.
// PARAMETERS
//  HALF_IMG_W  400  active pixels per half line; also the right-half line buffer depth
//  PX_WIDTH    8    bits per pixel
//  ADDR_W      9    line buffer address width; must satisfy 2**ADDR_W >= HALF_IMG_W
// PORTS
//  clk          in   1         pixel clock; the only clock
//  rst          in   1         synchronous, active-high reset
//  de_in        in   1         data enable, high for the half-width active part of a line
//  h_sync_in    in   1         horizontal sync
//  v_sync_in    in   1         vertical sync
//  pixel_left   in   PX_WIDTH  left-half pixel, valid when de_in=1
//  pixel_right  in   PX_WIDTH  right-half pixel, valid when de_in=1
//  clk_out      out  1         equal to clk (combinational pass-through)
//  de_out       out  1         data enable, high for the full merged line
//  h_sync_out   out  1         h_sync_in delayed by exactly 1 clk
//  v_sync_out   out  1         v_sync_in delayed by exactly 1 clk
//  pixel_out    out  PX_WIDTH  merged pixel
//  overrun      out  1         1-clk pulse: a protocol violation was detected (see below)
// BEHAVIOUR
//  - Reset: de_out, h_sync_out, v_sync_out, pixel_out and overrun all 0; state IDLE;
//    write and read pointers 0. Line buffer contents are not cleared.
//  - Latency is 1 clk. Input cycle n maps to output cycle n+1, for both data and sync.
//  - FSM states: IDLE, LEFT, RIGHT.
//  - IDLE, de_in=1: go to LEFT and process this cycle as LEFT pixel 0.
//  - LEFT, de_in=1: pixel_out<=pixel_left; de_out<=1; buf[wr_ptr]<=pixel_right; wr_ptr++.
//  - LEFT, de_in=0: len<=wr_ptr; issue read of buf[0]; go to RIGHT; de_out stays 1.
//    The right half therefore follows the last left pixel with no gap.
//  - RIGHT: pixel_out<=buf[rd_ptr] (registered read); de_out<=1; stays for exactly len
//    cycles, then de_out<=0, pointers cleared, go to IDLE.
//  - Output line length is 2*len, where len is the number of de_in cycles in that line.
//    Lines shorter than HALF_IMG_W are merged correctly.
//  - Over-long line: if de_in stays high past HALF_IMG_W pixels, the extra pixels are dropped.
//    wr_ptr saturates at HALF_IMG_W, so buffer writes stop, but left pixels still pass through.
//    overrun pulses once, on the first dropped pixel.
//  - Re-entry during RIGHT: if de_in rises while in RIGHT (blanking shorter than len),
//    overrun pulses, the right readout is aborted, and the FSM enters LEFT for the new line.
//    de_out stays continuously high.
//  - Sync signals are not gated or regenerated. The source must place h_sync at least
//    HALF_IMG_W cycles after de_in falls; this is met natively by half_img output timing.
//  - Reset asserted mid-line: outputs go to 0 on the next clk; the partial line is discarded.
//    The next de_in rise starts a clean line.
//  - pixel_out is 0 whenever de_out=0.
// STRUCTURE
//  - Shared defs include (video_defs.vh): FSM state encodings and PX_WIDTH default.
//  - Sub-module line_buffer_sdp: simple dual-port RAM, HALF_IMG_W x PX_WIDTH, 1 write port,
//    1 read port, registered read (1 clk). Reusable by rank_transform line stores.
//  - Top level holds the FSM, pointers, len register, the 1-clk sync pipeline and the output mux.
// TESTING  (HALF_IMG_W=4, PX_WIDTH=8 unless stated)
//  1. Normal line: de_in high 4 clk, left=10,11,12,13, right=20,21,22,23, then 8 blank clk
//     -> de_out high 8 clk starting 1 clk after de_in rises; pixel_out=10..13,20..23; overrun=0.
//  2. Short line: de_in high 2 clk, left=1,2, right=7,8
//     -> de_out high 4 clk; pixel_out=1,2,7,8.
//  3. Long line: de_in high 6 clk -> first 4 right pixels kept; de_out high 10 clk;
//     overrun pulses once, 1 clk after input pixel 4.
//  4. Re-entry: de_in rises again 2 clk after falling -> overrun pulse; pixel_out shows
//     2 right pixels, then the new line's left pixels; de_out never drops.
//  5. Sync alignment: h_sync_in/v_sync_in pulses at arbitrary cycles -> identical pulses
//     exactly 1 clk later.
//  6. Reset in RIGHT after 1 right pixel -> all outputs 0 next clk;
//     a following clean line merges as in case 1.
//  Full frame: HALF_IMG_W=400 fed from half_img, dumped through grayscale_out (hr=800);
//  the output PGM must equal the side-by-side input.

Source files
------------

// File: rtl/half_img_merge_pkg.sv
// Shared definitions for the side-by-side line merger.
// FSM encodings and default pixel width.
package half_img_merge_pkg;

  localparam int PX_WIDTH_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

endpackage

// File: rtl/half_img_merge_if.sv
// Video stream bundle: half-width stereo input,
// full-width merged output.
interface half_img_merge_if #(
  parameter int PX_WIDTH = 8
);

  logic                de_in;
  logic                h_sync_in;
  logic                v_sync_in;
  logic [PX_WIDTH-1:0] pixel_left;
  logic [PX_WIDTH-1:0] pixel_right;

  logic                clk_out;
  logic                de_out;
  logic                h_sync_out;
  logic                v_sync_out;
  logic [PX_WIDTH-1:0] pixel_out;
  logic                overrun;

  modport master (
    output de_in, h_sync_in, v_sync_in,
    output pixel_left, pixel_right,
    input  clk_out, de_out, h_sync_out,
    input  v_sync_out, pixel_out, overrun
  );

  modport slave (
    input  de_in, h_sync_in, v_sync_in,
    input  pixel_left, pixel_right,
    output clk_out, de_out, h_sync_out,
    output v_sync_out, pixel_out, overrun
  );

endinterface

// File: rtl/half_img_merge_line_buffer_sdp.sv
// Simple dual-port line store: one write port,
// one read port with a registered (1 clk) read.
module line_buffer_sdp #(
  parameter int DEPTH  = 400,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [WIDTH-1:0]  rd
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[wa] <= wd;
    if (re)
      rd <= mem[ra];
  end

endmodule

// File: rtl/half_img_merge.sv
// Rebuilds a side-by-side line from a stream carrying
// left and right pixels together; right half is replayed.
module half_img_merge
  import half_img_merge_pkg::*;
#(
  parameter int HALF_IMG_W = 400,
  parameter int PX_WIDTH   = PX_WIDTH_DEF,
  parameter int ADDR_W     = 9
) (
  input  logic             clk,
  input  logic             rst,
  half_img_merge_if.slave  vid
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] HALF = CW'(HALF_IMG_W);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [1:0]          state;
  logic [CW-1:0]       wr_ptr;
  logic [CW-1:0]       rd_ptr;
  logic [CW-1:0]       len;
  logic                dropped;
  logic                de_q;
  logic                sel_ram;
  logic                ovr_q;
  logic                hs_q;
  logic                vs_q;
  logic [PX_WIDTH-1:0] left_q;
  logic [PX_WIDTH-1:0] ram_q;

  logic                new_line;
  logic [CW-1:0]       wr_base;
  logic                wr_en;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_done;

  // A new line restarts the write pointer even mid-readout.
  always_comb begin
    new_line = vid.de_in && (state != ST_LEFT);
    wr_base  = new_line ? '0 : wr_ptr;
    wr_en    = vid.de_in && (wr_base < HALF);
    rd_done  = (rd_ptr == len);
    rd_addr  = (state == ST_LEFT) ? '0
                                  : rd_ptr[ADDR_W-1:0];
    rd_en    = 1'b0;
    if (!vid.de_in) begin
      if (state == ST_LEFT)
        rd_en = 1'b1;
      else if (state == ST_RIGHT && !rd_done)
        rd_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      len     <= '0;
      dropped <= 1'b0;
      de_q    <= 1'b0;
      sel_ram <= 1'b0;
      ovr_q   <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      left_q  <= '0;
    end else begin
      hs_q  <= vid.h_sync_in;
      vs_q  <= vid.v_sync_in;
      ovr_q <= 1'b0;
      if (vid.de_in) begin
        state   <= ST_LEFT;
        de_q    <= 1'b1;
        sel_ram <= 1'b0;
        left_q  <= vid.pixel_left;
        rd_ptr  <= '0;
        wr_ptr  <= wr_en ? wr_base + ONE : wr_base;
        if (new_line)
          dropped <= 1'b0;
        // Aborted readout, or first pixel beyond buffer depth.
        if (state == ST_RIGHT && !rd_done) begin
          ovr_q <= 1'b1;
        end else if (!new_line && !wr_en && !dropped) begin
          ovr_q   <= 1'b1;
          dropped <= 1'b1;
        end
      end else begin
        unique case (state)
          ST_LEFT: begin
            len     <= wr_ptr;
            rd_ptr  <= ONE;
            state   <= ST_RIGHT;
            sel_ram <= 1'b1;
            de_q    <= 1'b1;
          end
          ST_RIGHT: begin
            if (rd_done) begin
              state   <= ST_IDLE;
              de_q    <= 1'b0;
              sel_ram <= 1'b0;
              rd_ptr  <= '0;
              wr_ptr  <= '0;
            end else begin
              rd_ptr <= rd_ptr + ONE;
            end
          end
          default: begin
            state   <= ST_IDLE;
            de_q    <= 1'b0;
            sel_ram <= 1'b0;
          end
        endcase
      end
    end
  end

  line_buffer_sdp #(
    .DEPTH  (HALF_IMG_W),
    .WIDTH  (PX_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk (clk),
    .we  (wr_en),
    .wa  (wr_base[ADDR_W-1:0]),
    .wd  (vid.pixel_right),
    .re  (rd_en),
    .ra  (rd_addr),
    .rd  (ram_q)
  );

  assign vid.clk_out    = clk;
  assign vid.de_out     = de_q;
  assign vid.h_sync_out = hs_q;
  assign vid.v_sync_out = vs_q;
  assign vid.overrun    = ovr_q;
  assign vid.pixel_out  = !de_q   ? '0
                        : sel_ram ? ram_q
                                  : left_q;

endmodule

// File: tb/tb_half_img_merge.sv
// Bench for half_img_merge: directed lines plus random
// lines, checked against a queue-based line model.
module tb_half_img_merge;

  localparam int HALF = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  half_img_merge_if #(.PX_WIDTH(8)) vid();

  half_img_merge #(
    .HALF_IMG_W (HALF),
    .PX_WIDTH   (8),
    .ADDR_W     (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vid (vid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: right pixels kept for the current line.
  logic [7:0] kept[$];
  bit collecting = 0;
  bit draining   = 0;
  bit ovflag     = 0;

  logic       exp_de, exp_ov, exp_hs, exp_vs;
  logic [7:0] exp_px;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h at %0t",
             tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit de,
                       input logic [7:0] l,
                       input logic [7:0] rr,
                       input bit h, input bit v);
    exp_de = 0; exp_px = 0; exp_ov = 0;
    exp_hs = 0; exp_vs = 0;
    if (r) begin
      kept.delete();
      collecting = 0;
      draining   = 0;
      ovflag     = 0;
      return;
    end
    exp_hs = h;
    exp_vs = v;
    if (de) begin
      if (draining) begin
        exp_ov   = 1;
        draining = 0;
      end
      if (!collecting) begin
        collecting = 1;
        ovflag     = 0;
        kept.delete();
      end
      exp_de = 1;
      exp_px = l;
      if (kept.size() < HALF) begin
        kept.push_back(rr);
      end else if (!ovflag) begin
        exp_ov = 1;
        ovflag = 1;
      end
    end else begin
      if (collecting) begin
        collecting = 0;
        draining   = 1;
      end
      if (draining) begin
        exp_de = 1;
        exp_px = kept.pop_front();
        if (kept.size() == 0)
          draining = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit de,
                      input logic [7:0] l,
                      input logic [7:0] rr,
                      input bit h, input bit v);
    rst             = r;
    vid.de_in       = de;
    vid.pixel_left  = l;
    vid.pixel_right = rr;
    vid.h_sync_in   = h;
    vid.v_sync_in   = v;
    model(r, de, l, rr, h, v);
    @(posedge clk);
    #1;
    chk("de",  8'(vid.de_out),     8'(exp_de));
    chk("px",  vid.pixel_out,      exp_px);
    chk("ovr", 8'(vid.overrun),    8'(exp_ov));
    chk("hs",  8'(vid.h_sync_out), 8'(exp_hs));
    chk("vs",  8'(vid.v_sync_out), 8'(exp_vs));
    chk("clk", 8'(vid.clk_out),    8'(clk));
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 8'h0, 8'h0, 0, 0);
  endtask

  task automatic line(input int n,
                      input logic [7:0] l0,
                      input logic [7:0] r0);
    for (int i = 0; i < n; i++)
      step(0, 1, l0 + 8'(i), r0 + 8'(i), 0, 0);
  endtask

  initial begin
    vid.de_in       = 0;
    vid.pixel_left  = 0;
    vid.pixel_right = 0;
    vid.h_sync_in   = 0;
    vid.v_sync_in   = 0;

    step(1, 0, 8'h0, 8'h0, 0, 0);
    step(1, 1, 8'h55, 8'h66, 1, 1);
    blank(3);

    // Normal line.
    line(4, 8'd10, 8'd20);
    blank(8);
    // Short line.
    line(2, 8'd1, 8'd7);
    blank(6);
    // Over-long line.
    line(6, 8'd40, 8'd50);
    blank(12);
    // Re-entry after 2 blank cycles.
    line(4, 8'd60, 8'd70);
    blank(2);
    line(4, 8'd80, 8'd90);
    blank(10);
    // Blanking exactly equal to len: no overrun.
    line(3, 8'd100, 8'd110);
    blank(3);
    line(3, 8'd120, 8'd130);
    blank(8);
    // Sync pulses at arbitrary points.
    step(0, 0, 8'h0, 8'h0, 1, 0);
    step(0, 0, 8'h0, 8'h0, 0, 1);
    step(0, 1, 8'h3, 8'h4, 1, 1);
    step(0, 0, 8'h0, 8'h0, 0, 0);
    step(0, 0, 8'h0, 8'h0, 1, 0);
    blank(4);
    // Reset during readout after one right pixel.
    line(4, 8'd140, 8'd150);
    blank(1);
    step(1, 0, 8'h0, 8'h0, 0, 0);
    blank(2);
    line(4, 8'd10, 8'd20);
    blank(8);

    for (int k = 0; k < 40; k++) begin
      int n;
      int b;
      n = int'($urandom_range(1, 6));
      b = int'($urandom_range(1, 9));
      for (int i = 0; i < n; i++)
        step(0, 1, 8'($urandom), 8'($urandom),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      for (int i = 0; i < b; i++)
        step(0, 0, 8'($urandom), 8'($urandom),
             1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end
    blank(12);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
